// File: rtl/vga_pkg.sv
// Shared raster timing constants and types for the VGA scan controller.
// Default timing is 640x480@60 with a 25 MHz pixel rate from a 50 MHz clk.
// Optional feature macro used by the top: VGA_FRAMECNT_EN (frame counter output).
package vga_pkg;

  // Default 640x480@60 timing, in pixels and lines
  localparam int unsigned VGA_CLK_DIV  = 2;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  // Derived default totals and sync windows (inclusive bounds)
  localparam int unsigned H_TOTAL     = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int unsigned V_TOTAL     = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int unsigned HSYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int unsigned HSYNC_END   = HSYNC_START + VGA_H_SYNC - 1;
  localparam int unsigned VSYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int unsigned VSYNC_END   = VSYNC_START + VGA_V_SYNC - 1;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } rgb_t;

  // Inclusive window test used for both sync pulses
  function automatic logic in_window(input coord_t c, input coord_t lo, input coord_t hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_scan_ctrl_if.sv
// Coordinate-out / colour-in bus between the scan controller and the compositor.
// The scan controller is the master: it drives x,y and samples r,g,b.
// The compositor is a pure combinational responder; there is no handshake.
interface vga_scan_ctrl_if;
  import vga_pkg::*;

  coord_t     x;
  coord_t     y;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;

  modport master (output x, y, input r, g, b);
  modport slave  (input x, y, output r, g, b);

endinterface

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: counts clk cycles within one pixel period.
// pix_tick_o is high in the last clk of each pixel; vga_clk_o is registered.
// vga_clk_o is low for the first half of the pixel so its rising edge lands mid-pixel.
module vga_pix_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_tick_o,
  output logic vga_clk_o
);

  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] div_q, div_d;
  logic          vga_clk_q, vga_clk_d;

  // Next divider count and the pixel-clock level that goes with it
  always_comb begin
    div_d     = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    vga_clk_d = (div_d >= DIV_HALF);
  end

  // Divider state; vga_clk_q always reflects the current div_q phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      vga_clk_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      vga_clk_q <= vga_clk_d;
    end
  end

  assign pix_tick_o = (div_q == DIV_LAST);
  assign vga_clk_o  = vga_clk_q;

endmodule

// File: rtl/vga_scan_ctrl.sv
// Raster timing master: h/v counters drive x,y; compositor colour is registered to the DAC.
// DAC colour, sync and blank_n lag x,y by exactly one pixel and are mutually aligned.
// No backpressure: the compositor must settle r,g,b within one pixel; VGA_FRAMECNT_EN adds frame_cnt.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV   = VGA_CLK_DIV,
  parameter int unsigned H_ACTIVE  = VGA_H_ACTIVE,
  parameter int unsigned H_FP      = VGA_H_FP,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BP      = VGA_H_BP,
  parameter int unsigned V_ACTIVE  = VGA_V_ACTIVE,
  parameter int unsigned V_FP      = VGA_V_FP,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BP      = VGA_V_BP,
  parameter logic [23:0] BLANK_RGB = 24'h000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vga_scan_ctrl_if.master        sprite,
  output logic [7:0]             vga_r,
  output logic [7:0]             vga_g,
  output logic [7:0]             vga_b,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   blank_n,
  output logic                   sync_n,
  output logic                   vga_clk,
  output logic                   pix_tick,
  output logic                   frame_start
`ifdef VGA_FRAMECNT_EN
  ,
  output logic [15:0]            frame_cnt
`endif
);

  // Line/frame geometry for this instance
  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST  = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST  = coord_t'(V_TOT - 1);
  localparam coord_t H_VIS   = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS   = coord_t'(V_ACTIVE);
  localparam coord_t HS_LO   = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_HI   = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_LO   = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_HI   = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic   tick;
  logic   act;
  logic   h_wrap;
  logic   v_wrap;
  rgb_t   pix_in;

  coord_t h_q, h_d;
  coord_t v_q, v_d;
  rgb_t   rgb_q, rgb_d;
  logic   blank_n_q, blank_n_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;

  vga_pix_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_tick_o (tick),
    .vga_clk_o  (vga_clk)
  );

  // Pixel visibility and wrap conditions, all from the pre-increment counters
  always_comb begin
    act    = (h_q < H_VIS) && (v_q < V_VIS);
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    pix_in = {sprite.b, sprite.g, sprite.r};
  end

  // Counter advance and output-stage load, both only on a pixel tick
  always_comb begin
    h_d       = h_q;
    v_d       = v_q;
    rgb_d     = rgb_q;
    blank_n_d = blank_n_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    if (tick) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = v_wrap ? '0 : v_q + coord_t'(1);
      end else begin
        h_d = h_q + coord_t'(1);
      end
      // r/g/b are only sampled here, and only while the pixel is visible
      rgb_d     = act ? pix_in : rgb_t'(BLANK_RGB);
      blank_n_d = act;
      hsync_d   = ~in_window(h_q, HS_LO, HS_HI);
      vsync_d   = ~in_window(v_q, VS_LO, VS_HI);
    end
  end

  // Raster counters and registered DAC outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q       <= '0;
      v_q       <= '0;
      rgb_q     <= '0;
      blank_n_q <= 1'b0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      rgb_q     <= rgb_d;
      blank_n_q <= blank_n_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

`ifdef VGA_FRAMECNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Free-running frame count for animation; wraps naturally at 16 bits
  always_comb begin
    frame_cnt_d = frame_start ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  // Frame counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  // Renderers see the live counters, stable for the whole pixel period
  assign sprite.x    = h_q;
  assign sprite.y    = v_q;

  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign blank_n     = blank_n_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign sync_n      = 1'b0;
  assign pix_tick    = tick;
  assign frame_start = tick && h_wrap && v_wrap;

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
- Raster timing master for the 640x480@60 VGA output path.
- Generates the pixel coordinates x/y that every sprite renderer consumes.
- Samples the composited r/g/b the renderers return, and drives the registered DAC colour and sync pins.
- Sits at the top level between the sprite/background compositor and the board VGA DAC; it is the requesting end of the coordinate-in / colour-out sprite interface.

Parameters:
- CLK_DIV, 2: clk cycles per pixel (50 MHz clk gives a 25 MHz pixel rate); legal values are 2 and above.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines.
- BLANK_RGB, 24'h000000: colour driven during blanking, ordered {b,g,r}.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- x  out  10  current horizontal counter, 0..H_TOTAL-1
- y  out  10  current vertical counter, 0..V_TOTAL-1
- r  in  8  compositor red for (x,y)
- g  in  8  compositor green for (x,y)
- b  in  8  compositor blue for (x,y)
- vga_r  out  8  registered red to DAC
- vga_g  out  8  registered green to DAC
- vga_b  out  8  registered blue to DAC
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- blank_n  out  1  high while the registered pixel is visible
- sync_n  out  1  DAC composite sync, tied low
- vga_clk  out  1  pixel clock to DAC, registered
- pix_tick  out  1  one-clk strobe marking a pixel advance
- frame_start  out  1  one-clk pulse on the wrap to (0,0)

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low (rst_n), and all state resets.
- Reset values: div counter 0, h=0, v=0, vga_r/g/b=0, hsync=1, vsync=1, blank_n=0, vga_clk=0, pix_tick=0, frame_start=0.
- Pixel tick: div counts 0..CLK_DIV-1. pix_tick=1 in the cycle div==CLK_DIV-1.
- vga_clk: 0 for div < CLK_DIV/2, 1 otherwise (registered). The rising edge lands mid-pixel.
- Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP=800; V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP=525.
- Counter advance, on pix_tick only:
  - h<H_TOTAL-1: h++.
  - Otherwise h=0, and v advances: v++, or v=0 when v==V_TOTAL-1.
- x and y are driven directly from the h and v registers. They are stable for CLK_DIV clks, so the combinational renderers have a full pixel period to settle.
- Output stage, on pix_tick, loaded from the pre-increment h,v:
  - act = (h<H_ACTIVE) && (v<V_ACTIVE).
  - {vga_b,vga_g,vga_r} <= act ? {b,g,r} : BLANK_RGB.
  - blank_n <= act.
  - hsync <= ~(h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]).
  - vsync <= ~(v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]).
- Latency: DAC pins lag x,y by exactly one pixel. Colour, sync and blank_n are mutually aligned.
- frame_start: 1 in the pix_tick cycle where h==H_TOTAL-1 && v==V_TOTAL-1. Game logic updates sprite positions on this pulse.
- Reset mid-frame: everything returns to the reset values immediately. The first tick after release starts at (0,0), and frame_start does not fire until the first full wrap.
- Input r/g/b are ignored outside act, and in all non-tick cycles.
- No other handshake exists; the compositor is a pure responder.

Optional Feature:
- VGA_FRAMECNT_EN defined: adds output frame_cnt[15:0].
  - Resets to 0.
  - Increments on each frame_start and wraps 16'hFFFF->0.
  - Used for sprite animation and coin blinking.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package vga_pkg holds:
  - The timing localparams (H_TOTAL, V_TOTAL, sync start/end).
  - typedef rgb_t, a packed struct {b,g,r} of 8 bits each.
  - typedef coord_t = logic [9:0].
- One natural sub-module: vga_pix_div. It owns the div counter and produces pix_tick and vga_clk. The main block holds the h/v counters and the output stage.

Test Plan:
- Reset then run 2 frames, checking tick spacing and totals:
  - pix_tick every 2 clks.
  - 800 ticks per line and 525 lines per frame.
  - frame_start period = 840000 clks.
- Sync pulse positions:
  - hsync low for exactly 96 ticks, the first low tick registered from h=656.
  - vsync low for lines 490-491.
- Data path, with r=x[7:0], g=y[7:0], b=8'hA5:
  - At the tick after (x=10,y=20) is presented, vga_r=10, vga_g=20, vga_b=A5, blank_n=1.
  - At the tick after x=640, vga_r/g/b=0 and blank_n=0.
- Wrap boundary:
  - At h=799,v=524, frame_start=1 for exactly 1 clk.
  - The next x,y=(0,0).
  - hsync and vsync are both 1 at the (0,0) output.
- Reset mid-frame:
  - Assert rst_n=0 asynchronously at (300,200) between clk edges.
  - Outputs go to reset values without waiting for clk.
  - After release, the count restarts at (0,0).
- VGA_FRAMECNT_EN:
  - frame_cnt=3 after 3 frame_start pulses.
  - Preload 16'hFFFF, then one frame_start -> 0.
